// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and types for the 4-digit 7-segment scanner.
//                Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
//                Anode vectors are active low, bit i drives digit i.
//  Revision    : 1.0  initial release
// ============================================================================
package display_pkg;

    // Segment patterns (active low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // All anodes off (active low)
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Digit index as presented to bin2BCD on sel
    typedef enum logic [1:0] {
        UNITS     = 2'd0,
        TENS      = 2'd1,
        HUNDREDS  = 2'd2,
        THOUSANDS = 2'd3
    } digit_idx_e;

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_scan_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD to 7-segment decoder, active-low outputs.
//                Values 10..15 show a dash (only segment g lit).
//  Ports       : bcd [3:0] in  - digit value
//                seg [6:0] out - {g,f,e,d,c,b,a}, active low
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan
//  Description : Time-multiplexed 4-digit 7-segment driver placed downstream
//                of bin2BCD. Presents the digit index on sel, decodes the
//                returned bcd digit and registers one-hot anode + segments.
//                Includes a refresh prescaler, optional leading-zero blanking
//                and an enable that freezes the scan and darkens the display.
//  Ports       : clk          in  - system clock, rising edge
//                rst_n        in  - asynchronous active-low reset
//                en           in  - 1 = scan/display, 0 = freeze + dark
//                blank_lz     in  - 1 = suppress leading zeros on digits 3..1
//                bcd  [3:0]   in  - digit from bin2BCD for current sel
//                sel  [1:0]   out - digit index (0 units .. 3 thousands)
//                an   [3:0]   out - anodes, active low
//                seg  [6:0]   out - segments {g..a}, active low
//  Revision    : 1.0  initial release
// ============================================================================
module display_scan
    import display_pkg::*;
#(
    parameter int COUNT_MAX = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] bcd,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int              CNT_W    = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    digit_idx_e       idx_q,  idx_d;
    logic             seen_q, seen_d;
    logic [3:0]       an_q,   an_d;
    logic [6:0]       seg_q,  seg_d;

    logic             tick;
    logic             blank;
    logic [6:0]       dec_seg;

    seg7_decode u_seg7_decode (
        .bcd (bcd),
        .seg (dec_seg)
    );

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        seen_d = seen_q;
        an_d   = AN_OFF;
        seg_d  = SEG_BLANK;

        tick = en && (cnt_q == CNT_LAST);

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        // Descending scan; the 2-bit index wraps 0 -> 3 naturally.
        if (tick) begin
            idx_d  = digit_idx_e'(idx_q - 2'd1);
            // Units is the last digit of a frame, so leaving it restarts the
            // leading-zero search for the next frame.
            seen_d = (idx_q == UNITS) ? 1'b0 : (seen_q | (bcd != 4'd0));
        end

        // seen only covers digits above the one currently on sel, which is
        // exactly what decides whether this zero is a leading zero.
        blank = blank_lz && (bcd == 4'd0) && !seen_q && (idx_q != UNITS);

        // Anode and segments come from the same idx/bcd and register on the
        // same edge, so a lit digit never shows a neighbour's pattern.
        an_d  = en ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d = (!en || blank) ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= THOUSANDS;
            seen_q <= 1'b0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seen_q <= seen_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign sel = idx_q;
    assign an  = an_q;
    assign seg = seg_q;

endmodule : display_scan
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan
//  Description : Self-checking bench for display_scan with COUNT_MAX = 4.
//                A behavioural bin2BCD feeds bcd from a test value and sel.
//                Expected an/seg/sel for every clocked cycle are queued when
//                the cycle is driven and compared after the clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scan;

    localparam int COUNT_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       blank_lz;
    logic [3:0] bcd;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;

    // Stimulus state
    int         sum;
    logic       force_on;
    int         force_digit;
    int         ecount;        // enabled cycles since last reset

    int         n_vec;
    int         n_fail;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] sel;
    } exp_t;

    exp_t sb[$];

    display_scan #(
        .COUNT_MAX (COUNT_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .blank_lz (blank_lz),
        .bcd      (bcd),
        .sel      (sel),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int d);
        case (d)
            0:       return 1;
            1:       return 10;
            2:       return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [3:0] digit_val(input int s, input int d);
        if (force_on && d == force_digit) return 4'hC;
        return 4'((s / pow10(d)) % 10);
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Behavioural bin2BCD: digit of sum selected by sel.
    always_comb begin
        bcd = digit_val(sum, int'(sel));
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Compare registered outputs away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("an",  16'(an),  16'(e.an));
            check_eq("seg", 16'(seg), 16'(e.seg));
            check_eq("sel", 16'(sel), 16'(e.sel));
        end
    end

    // Drive n cycles with the given enable, queueing expectations.
    task automatic run_cycles(input int n, input logic en_v);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   digit;
            logic all_zero;
            en    = en_v;
            digit = 3 - ((ecount / COUNT_MAX) % 4);
            // A digit is a leading zero if it and every higher digit is zero.
            all_zero = 1'b1;
            for (int k = digit; k < 4; k++)
                if (digit_val(sum, k) != 4'd0) all_zero = 1'b0;
            if (!en_v) begin
                e.an  = 4'b1111;
                e.seg = 7'h7F;
            end else begin
                e.an  = an_of(digit);
                e.seg = (blank_lz && digit != 0 && all_zero) ? 7'h7F
                                                             : seg_of(digit_val(sum, digit));
                ecount++;
            end
            e.sel = 2'(3 - ((ecount / COUNT_MAX) % 4));
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_an"},  16'(an),  16'h000F);
        check_eq({tag, "_seg"}, 16'(seg), 16'h007F);
        check_eq({tag, "_sel"}, 16'(sel), 16'h0003);
        repeat (2) @(negedge clk);
        #2;
        rst_n  = 1'b1;
        ecount = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        en          = 1'b1;
        blank_lz    = 1'b1;
        sum         = 584;
        force_on    = 1'b0;
        force_digit = 3;
        ecount      = 0;

        repeat (2) @(posedge clk);
        reset_check("rst");

        // 584: digit 3 blank, 5, 8, 4
        run_cycles(16, 1'b1);

        // 105: embedded zero shown; then without blanking
        sum = 105;
        run_cycles(16, 1'b1);
        blank_lz = 1'b0;
        run_cycles(16, 1'b1);
        blank_lz = 1'b1;

        // 0: only units lit, two frames across a wrap
        sum = 0;
        run_cycles(32, 1'b1);

        // en dropped mid digit 1, then resumed
        sum = 584;
        run_cycles(10, 1'b1);
        run_cycles(10, 1'b0);
        run_cycles(6,  1'b1);

        // Dash on digit 3 marks the number as started, so zeros show
        sum      = 0;
        force_on = 1'b1;
        run_cycles(16, 1'b1);
        force_on = 1'b0;
        run_cycles(16, 1'b1);

        // Reset mid-frame restarts the scan cleanly
        sum = 2047;
        run_cycles(7, 1'b1);
        @(negedge clk);
        reset_check("rst_mid");
        sum = 30;
        run_cycles(16, 1'b1);

        @(negedge clk);
        #1;
        check_eq("sb_drain", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_display_scan
`default_nettype wire

// File: doc/display_scan.md
Name: display_scan

Overview:
- Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of bin2BCD.
- Drives the `sel` digit index into bin2BCD and consumes the returned 4-bit `bcd` digit combinationally.
- Registers the decoded segment pattern and the one-hot anode for the board display.
- Adds a refresh prescaler, optional leading-zero blanking, and enable/blank control.

Parameters:
- COUNT_MAX, 50000: clock cycles each digit stays lit; must be ≥1; counter width is $clog2(COUNT_MAX) (minimum 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  1 = scan and display; 0 = freeze scan, all digits dark.
- blank_lz  input  1  1 = suppress leading zeros on digits 3..1.
- bcd  input  4  digit from bin2BCD for the current `sel`.
- sel  output  2  digit index to bin2BCD: 0 = units, 1 = tens, 2 = hundreds, 3 = thousands.
- an  output  4  anodes, active low; an[i] lights digit i.
- seg  output  7  segments, active low; bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, immediate):
  - prescaler cnt = 0, digit index idx = 3, seen flag = 0.
  - an = 4'b1111, seg = 7'h7F.
  - sel = idx, so sel = 3 during reset.
- sel is driven directly from the idx register, with no extra latency.
- Prescaler:
  - When en = 1, cnt increments each cycle.
  - tick = (en && cnt == COUNT_MAX-1); on tick, cnt returns to 0.
  - With COUNT_MAX = 1, tick fires every enabled cycle.
- Scan order is descending: idx 3→2→1→0→3, advancing only on tick.
  - One frame = 4*COUNT_MAX enabled cycles.
- Leading-zero tracking:
  - On tick, seen <= (idx == 0) ? 0 : (seen | (bcd != 0)).
  - This clears seen at frame wrap and accumulates nonzero digits.
  - Digits scan highest first, so seen is valid for the digit currently on sel.
- Blank condition: blank = blank_lz && bcd == 0 && !seen && idx != 0. Units are never blanked, so 0 shows as "0".
- Output registers, updated every cycle (1-cycle latency from idx/bcd):
  - an <= en ? ~(4'b0001 << idx) : 4'b1111
  - seg <= (!en || blank) ? 7'h7F : decode(bcd)
- Decode table (active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - bcd 10..15 → 7'h3F (dash, only g lit)
- Anode and segments update on the same edge, so the lit digit always shows its own pattern (no ghosting).
- en deassert:
  - cnt, idx and seen hold.
  - One cycle later, an = 1111 and seg = 7F.
  - Re-assert resumes from the held cnt and idx.
- bcd changing mid-digit: seg follows within 1 cycle. seen samples only at tick.
- Reset mid-frame: immediate return to reset values; scan restarts at idx 3 with seen = 0.

Decomposition:
- Package display_pkg holds:
  - SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F, the 10 digit segment constants, AN_OFF = 4'b1111.
  - The digit index enum: UNITS = 0, TENS = 1, HUNDREDS = 2, THOUSANDS = 3.
- One combinational sub-module, seg7_decode: bcd[3:0] → seg[6:0] active low, dash for values > 9.
- Prescaler, scan index, seen flag and output registers stay in display_scan.

Test Plan:
- Run all scenarios with COUNT_MAX = 4, bin2BCD instantiated, en = 1, blank_lz = 1.
- Reset: hold rst_n = 0 mid-clock → an = 1111, seg = 7F, sel = 3 asynchronously, without waiting for a clock edge; release → first tick after 4 cycles, sel = 2.
- sum = 584, full frame → digit 3 (an = 0111) seg = 7F (blank); digit 2 (an = 1011) seg = 12; digit 1 (an = 1101) seg = 00; digit 0 (an = 1110) seg = 19. Each digit lasts 4 cycles.
- sum = 105 → digit 3 blank (7F), digit 2 = 79, digit 1 = 40 (embedded zero shown), digit 0 = 12. Same sum with blank_lz = 0 → digit 3 = 40.
- sum = 0 → digits 3..1 = 7F, digit 0 = 40. Across a frame wrap, seen clears and the next frame repeats identically.
- en dropped for 10 cycles mid-digit 1 → an = 1111, seg = 7F one cycle later and sel held at 1. Re-enable → digit 1 finishes its remaining cycles, then sel = 0.
- Force bcd = 4'hC (bench drives the bcd port directly) → seg = 3F on the lit digit. That digit sets seen, so later zeros are not blanked.
